// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch-stage front end. Drives the program counter into a synchronous,
// byte-addressed instruction memory with one cycle of read latency, and
// buffers the returned instructions in a small in-order queue of
// {pc, instr} pairs. Decode pulls from that queue with a valid/ready
// handshake.
//
// A redirect (branch/jump) flushes the queue and any read in flight, then
// restarts fetch at the new address. When memory flags an out-of-range
// fetch (mem_stop), fetching halts. Once the queue has drained,
// fetch_done is raised.
//
// Parameters
//   DEPTH     instruction queue entries (power of two, >= 2)
//   RESET_PC  PC after reset (word aligned)
//
// Ports
//   clk             clock, all state changes on its rising edge
//   rstn            asynchronous active-low reset
//   mem_pc          fetch address to memory (always equal to pc_reg)
//   mem_instr       memory read data, valid the cycle after the address
//   mem_stop        out-of-range flag, same timing as mem_instr
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     restart address (bits [1:0] ignored)
//   out_valid       queue head valid toward decode
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction (0 when out_valid is low)
//   out_pc          PC of head instruction (0 when out_valid is low)
//   fetch_done      stop seen and queue empty
// ----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instr,
  input  logic        mem_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The limit is held one bit wider than count, so that count + inflight
  // never wraps.
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state;
  state_t             state_next;
  logic [31:0]        pc_reg;
  logic               inflight;
  logic [31:0]        inflight_pc;
  entry_t             queue [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  // --------------------------------------------------------------------------
  // Per-cycle decisions
  // --------------------------------------------------------------------------
  logic               pop;
  logic               push;
  logic               resp_stop;
  logic               issue;
  logic [CNT_W:0]     occupancy;
  logic [CNT_W-1:0]   count_after;
  logic [31:0]        redirect_aligned;
  logic               unused_redirect_bits;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // A response that comes back in a redirect cycle belongs to the old path.
  // It is dropped rather than queued.
  assign push      = inflight && !mem_stop && !redirect_valid;
  assign resp_stop = inflight && mem_stop;

  // Credit counts queued entries plus the read still in flight. A pop frees
  // its slot only from the next cycle. This keeps the check purely
  // registered, and the queue can never overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  // Issuing stops in the same cycle the stop response arrives, so nothing
  // is in flight once fetching has halted.
  assign issue = (state == S_FETCH) && !redirect_valid && !resp_stop
              && (occupancy < DEPTH_LIMIT);

  assign count_after = count
                     + {{(CNT_W-1){1'b0}}, push}
                     - {{(CNT_W-1){1'b0}}, pop};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held (no latch). Clocked blocks
  // use '<=' only, so all registers update together at the edge.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: begin
          // If the stop lands while the last entry pops, skip DRAIN.
          if (resp_stop) begin
            state_next = (count_after == '0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_after == '0) begin
            state_next = S_DONE;
          end
        end
        S_DONE:  state_next = S_DONE;
        default: state_next = S_FETCH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // PC and in-flight tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg      <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc_reg   <= redirect_aligned;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_reg;
      pc_reg      <= pc_reg + 32'd4;
    end else begin
      inflight <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_after;
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage
  // --------------------------------------------------------------------------
  // NOTE: the storage array has no reset. An entry is only ever read when
  // count marks it valid, so resetting count and the pointers is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      queue[tail] <= '{pc: inflight_pc, instr: mem_instr};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_pc     = pc_reg;
  assign out_instr  = out_valid ? queue[head].instr : '0;
  assign out_pc     = out_valid ? queue[head].pc    : '0;
  assign fetch_done = (state == S_DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. Two instances are used:
//   dut    RESET_PC = 0
//   h_dut  RESET_PC = 1012, which runs into the end of memory
// A synchronous memory model with one-cycle latency feeds each instance.
// The model flags stop for any address above 1016.
//
// The random phase keeps a scoreboard of the instruction stream:
//   - consecutive PCs from the last restart point
//   - the instruction word at each PC
//   - whether the stream has ended (last word accepted, no redirect since)
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] HI_PC   = 32'd1012;
  localparam logic [31:0] LAST_PC = 32'd1016;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with RESET_PC = 0
  logic        rstn;
  logic [31:0] mem_pc, mem_instr, redirect_pc, out_instr, out_pc;
  logic        mem_stop, redirect_valid, out_valid, out_ready, fetch_done;

  // Instance with RESET_PC = 1012
  logic        h_rstn;
  logic [31:0] h_mem_pc, h_mem_instr, h_redirect_pc, h_out_instr, h_out_pc;
  logic        h_mem_stop, h_redirect_valid, h_out_valid, h_out_ready, h_fetch_done;

  logic [31:0] mem_words [256];

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .mem_pc(mem_pc), .mem_instr(mem_instr),
    .mem_stop(mem_stop), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_done(fetch_done)
  );

  instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(HI_PC)) h_dut (
    .clk(clk), .rstn(h_rstn), .mem_pc(h_mem_pc), .mem_instr(h_mem_instr),
    .mem_stop(h_mem_stop), .redirect_valid(h_redirect_valid),
    .redirect_pc(h_redirect_pc), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_instr(h_out_instr), .out_pc(h_out_pc),
    .fetch_done(h_fetch_done)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    mem_instr   <= mem_words[mem_pc[9:2]];
    mem_stop    <= (mem_pc > LAST_PC);
    h_mem_instr <= mem_words[h_mem_pc[9:2]];
    h_mem_stop  <= (h_mem_pc > LAST_PC);
  end

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return mem_words[addr[9:2]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Holds the main instance in reset for two cycles, then releases it on a
  // falling edge with out_ready at the given level.
  task automatic reset_main(input logic ready);
    rstn           = 1'b0;
    out_ready      = ready;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Scoreboard state for the random phase.
  logic [31:0] exp_pc;
  logic        model_done;
  logic        after_redirect;

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;

    rstn             = 1'b1;
    h_rstn           = 1'b1;
    out_ready        = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    h_out_ready      = 1'b1;
    h_redirect_valid = 1'b0;
    h_redirect_pc    = '0;
    #1;
    rstn   = 1'b0;
    h_rstn = 1'b0;
    #2;

    // ---------------- Reset state ----------------
    check("rst_mem_pc",     mem_pc,     32'h0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_pc",     out_pc,     0);
    check("rst_out_instr",  out_instr,  0);
    check("rst_fetch_done", fetch_done, 0);
    check("rst_h_mem_pc",   h_mem_pc,   HI_PC);

    // ---------------- Streaming with out_ready = 1 ----------------
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_latency", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_valid", out_valid, 1);
      check("stream_pc",    out_pc,    32'(4 * k));
      check("stream_instr", out_instr, word_at(32'(4 * k)));
    end

    // ---------------- Full queue, then drain ----------------
    reset_main(1'b0);
    repeat (10) @(negedge clk);
    check("full_valid",  out_valid, 1);
    check("full_head",   out_pc,    32'h0);
    check("full_mem_pc", mem_pc,    32'd16);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("drain_valid", out_valid, 1);
      check("drain_pc",    out_pc,    32'(4 * k));
      check("drain_instr", out_instr, word_at(32'(4 * k)));
      @(negedge clk);
    end

    // ---------------- Redirect while the queue is full ----------------
    reset_main(1'b0);
    repeat (8) @(negedge clk);
    check("redir_pre_mem_pc", mem_pc, 32'd16);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_r1_valid",  out_valid, 0);
    check("redir_r1_mem_pc", mem_pc,    32'h100);
    @(negedge clk);
    check("redir_r2_valid", out_valid, 0);
    @(negedge clk);
    check("redir_r3_valid", out_valid, 1);
    check("redir_r3_pc",    out_pc,    32'h100);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("redir_seq_valid", out_valid, 1);
      check("redir_seq_pc",    out_pc,    32'h100 + 32'(4 * k));
      check("redir_seq_instr", out_instr, word_at(32'h100 + 32'(4 * k)));
      @(negedge clk);
    end

    // ---------------- End of memory (RESET_PC = 1012) ----------------
    @(negedge clk);
    h_rstn = 1'b1;
    @(negedge clk);
    check("end_latency", h_out_valid, 0);
    @(negedge clk);
    check("end_pc0",    h_out_pc,     32'd1012);
    check("end_instr0", h_out_instr,  word_at(32'd1012));
    check("end_done0",  h_fetch_done, 0);
    @(negedge clk);
    check("end_pc1",    h_out_pc,     32'd1016);
    check("end_valid1", h_out_valid,  1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("end_done",  h_fetch_done, 1);
      check("end_idle",  h_out_valid,  0);
      check("end_pc_zero", h_out_pc,   0);
    end

    // Redirect out of DONE back to address 0.
    h_redirect_valid = 1'b1;
    h_redirect_pc    = 32'h0;
    @(negedge clk);
    h_redirect_valid = 1'b0;
    check("resume_done_drop", h_fetch_done, 0);
    check("resume_r1_valid",  h_out_valid,  0);
    @(negedge clk);
    check("resume_r2_valid", h_out_valid, 0);
    @(negedge clk);
    check("resume_r3_valid", h_out_valid, 1);
    check("resume_r3_pc",    h_out_pc,    32'h0);
    check("resume_r3_instr", h_out_instr, word_at(32'h0));
    @(negedge clk);
    check("resume_r4_pc", h_out_pc, 32'h4);

    // ---------------- Randomized traffic against the scoreboard ----------------
    reset_main(1'b0);
    exp_pc         = 32'h0;
    model_done     = 1'b0;
    after_redirect = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("rnd_done", fetch_done, model_done);
      if (after_redirect || model_done) check("rnd_idle", out_valid, 0);
      if (out_valid) begin
        check("rnd_pc",    out_pc,    exp_pc);
        check("rnd_instr", out_instr, word_at(exp_pc));
      end else begin
        check("rnd_pc_zero",    out_pc,    0);
        check("rnd_instr_zero", out_instr, 0);
      end

      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) redirect_pc = 32'($urandom_range(900, 1019));
      else                           redirect_pc = 32'($urandom_range(0, 1019));

      // An accepted head counts even in a redirect cycle. The redirect then
      // sets the restart point.
      after_redirect = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_pc == LAST_PC) model_done = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc         = {redirect_pc[31:2], 2'b00};
        model_done     = 1'b0;
        after_redirect = 1'b1;
      end
    end

    // ---------------- Asynchronous reset mid-stream ----------------
    @(negedge clk);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check("async_pre_valid", out_valid, 1);
    rstn   = 1'b0;
    h_rstn = 1'b0;
    #1;
    check("async_valid",    out_valid,  0);
    check("async_done",     fetch_done, 0);
    check("async_instr",    out_instr,  0);
    check("async_pc",       out_pc,     0);
    check("async_mem_pc",   mem_pc,     32'h0);
    check("async_h_mem_pc", h_mem_pc,   HI_PC);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("restart_latency", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("restart_valid", out_valid, 1);
      check("restart_pc",    out_pc,    32'(4 * k));
      check("restart_instr", out_instr, word_at(32'(4 * k)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage front end that drives the program counter into the synchronous byte-addressed instruction memory (1024 bytes, one-cycle read latency, `stop` flag on out-of-range fetch) and buffers returned instructions for decode. It keeps a small in-order queue of {pc, instr} pairs with a valid/ready handshake toward decode. It also accepts a redirect (branch/jump) that flushes everything in flight. On a memory `stop` it halts fetching and signals completion once the queue drains.

## Interface
- `DEPTH`, 4: instruction queue entries (power of two, ≥2).
- `RESET_PC`, 32'h0: PC after reset; word-aligned.
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `mem_pc`  out  32  address to instruction memory.
- `mem_instr`  in  32  instruction returned by memory, valid the cycle after the address was presented.
- `mem_stop`  in  1  memory out-of-range flag, same timing as `mem_instr`.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `out_valid`  out  1  queue head valid toward decode.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  PC of head instruction.
- `fetch_done`  out  1  stop seen and queue empty.

## Operation
- Registers: `pc_reg`, `inflight` (1 bit), `inflight_pc`, queue (DEPTH × 64 bits, head/tail pointers, count of width log2(DEPTH)+1), state.
- `mem_pc` = `pc_reg` combinationally at all times. Memory reads every cycle. Only cycles flagged as issue are tracked.
- States: FETCH, DRAIN, DONE.
- Issue (FETCH only, no redirect): when count + inflight < DEPTH. Effects: `inflight`<=1, `inflight_pc`<=`pc_reg`, `pc_reg`<=`pc_reg`+4 (32-bit wrap). Otherwise `inflight`<=0 and `pc_reg` holds. A pop in the same cycle frees credit only from the next cycle, so the queue can never overflow.
- Response: when `inflight`=1 and `mem_stop`=0, push {`inflight_pc`, `mem_instr`} at tail. When `inflight`=1 and `mem_stop`=1, discard it, stop issuing, and go to DRAIN.
- `mem_instr` is stored unmodified; byte order is owned by memory.
- Pop: `out_valid` && `out_ready`. Push and pop in the same cycle leave count unchanged.
- DRAIN: no issue. Go to DONE when count=0, or in the same cycle the last entry pops.
- DONE: `fetch_done`=1, no issue, `pc_reg` holds.
- Redirect has the highest priority and applies in any state:
  - queue cleared (count=0, pointers reset), `inflight`<=0 (a response arriving this cycle is dropped);
  - `pc_reg`<={`redirect_pc`[31:2],2'b00}, state<=FETCH, no issue this cycle.
  - A decode handshake in the redirect cycle still counts as accepted by decode.
- `out_instr`/`out_pc` show the queue head when `out_valid`=1, and 0 otherwise.

## Timing
- Reset (asynchronous, immediate):
  - `pc_reg`=RESET_PC, so `mem_pc`=RESET_PC.
  - `inflight`=0, count=0, state=FETCH.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `fetch_done`=0.
- Request presented in cycle t → memory samples at posedge ending t → response visible in t+1 → queued at posedge ending t+1 → `out_valid` earliest in t+2.
- First issue is in the first cycle after `rstn` deasserts.
- Steady state with `out_ready`=1: one instruction per cycle, no bubbles (requires DEPTH ≥ 2).
- Redirect in cycle r: `out_valid`=0 in r+1; first issue at r+1; first redirected instruction visible in r+3.
- `fetch_done` rises the cycle after the queue becomes empty in DRAIN.
- `fetch_done` falls the cycle after a redirect.

## Test plan
- Reset, then `out_ready`=1 constantly → `out_valid` first high 2 cycles after reset release. `out_pc` sequence 0,4,8,12… one per cycle; `out_instr` matches memory words.
- `out_ready`=0 from reset → exactly 4 entries (pc 0,4,8,12) held; `pc_reg`=16; `mem_pc` holds 16. Then raise `out_ready` → pcs 0,4,8,12,16,20 with no gaps or duplicates.
- RESET_PC=1012, `out_ready`=1 → outputs pc 1012 then 1016. The 1020 request returns `mem_stop`=1 and is discarded. `fetch_done`=1 one cycle after the 1016 pop. No further output.
- Queue full (pc 0..12), then pulse `redirect_pc`=32'h103 → next cycle `out_valid`=0. Then outputs pc 0x100, 0x104, … and no stale pc 0..16 ever appears.
- In DONE, pulse `redirect_pc`=0 → `fetch_done` drops next cycle and fetch resumes at pc 0.
- Assert `rstn`=0 mid-stream, between clock edges → `out_valid`, `fetch_done`, `out_instr`, `out_pc` go to 0 immediately and `mem_pc`=RESET_PC. After release, the sequence restarts from RESET_PC.
